// File: rtl/regfile_sequencer.sv
// Command sequencer for the 16x8 register unit: turns READ/WRITE/COPY/FILL commands
// into load/store cycles on the unit's port and returns one response per command.
module regfile_sequencer #(
    parameter int REGISTER_COUNT = 16,
    parameter int REGISTER_SIZE  = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [$clog2(REGISTER_COUNT)-1:0] cmd_addr,
    input  logic [$clog2(REGISTER_COUNT)-1:0] cmd_dst,
    input  logic [$clog2(REGISTER_COUNT)-1:0] cmd_count,
    input  logic [REGISTER_SIZE-1:0]          cmd_data,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [REGISTER_SIZE-1:0]          rsp_data,
    output logic                              busy,
    output logic                              rf_load,
    output logic                              rf_store,
    output logic [$clog2(REGISTER_COUNT)-1:0] rf_load_addr,
    output logic [$clog2(REGISTER_COUNT)-1:0] rf_store_addr,
    output logic [REGISTER_SIZE-1:0]          rf_data_in,
    input  logic [REGISTER_SIZE-1:0]          rf_data_out,
    output logic [2:0]                        dbg_state
);

    localparam int AW = $clog2(REGISTER_COUNT);
    localparam int DW = REGISTER_SIZE;
    localparam logic [AW:0]   FULL_LEN = (AW+1)'(REGISTER_COUNT);
    localparam logic [AW:0]   IDX_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WR       = 3'd3,
        S_COPY     = 3'd4,
        S_FILL     = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_dst;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_rsp_data;
    logic [AW:0]   r_len;
    logic [AW:0]   r_idx;
    logic          w_accept;
    logic [AW:0]   w_len_in;
    logic [AW-1:0] w_idx_lo;

    // Both handshakes transfer on a rising edge where valid and ready are high together;
    // cmd_ready depends only on state, rsp_valid/rsp_data hold until rsp_ready is seen.
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_len_in  = (cmd_count == '0) ? FULL_LEN : {1'b0, cmd_count};
    assign w_idx_lo  = r_idx[AW-1:0];
    assign dbg_state = r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_dst      <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
            r_len      <= '0;
            r_idx      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr     <= cmd_addr;
                r_dst      <= cmd_dst;
                r_data     <= cmd_data;
                r_len      <= w_len_in;
                r_idx      <= '0;
                r_rsp_data <= '0;
            end else begin
                if (r_state == S_COPY || r_state == S_FILL) begin
                    r_idx <= r_idx + IDX_ONE;
                end
                // Register unit data is valid the cycle after the load
                if (r_state == S_RD_WAIT) begin
                    r_rsp_data <= rf_data_out;
                end
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        busy          = 1'b1;
        rf_load       = 1'b0;
        rf_store      = 1'b0;
        rf_load_addr  = '0;
        rf_store_addr = '0;
        rf_data_in    = '0;

        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b00:   w_state_next = S_RD_ISSUE;
                        2'b01:   w_state_next = S_WR;
                        2'b10:   w_state_next = S_COPY;
                        default: w_state_next = S_FILL;
                    endcase
                end
            end
            S_RD_ISSUE: begin
                rf_load      = 1'b1;
                rf_load_addr = r_addr;
                w_state_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_state_next = S_RESP;
            end
            S_WR: begin
                rf_store      = 1'b1;
                rf_store_addr = r_addr;
                rf_data_in    = r_data;
                w_state_next  = S_RESP;
            end
            S_COPY: begin
                // Element i is loaded at index i and stored at index i+1, so the
                // store trails the load by one cycle and both overlap mid-block.
                if (r_idx < r_len) begin
                    rf_load      = 1'b1;
                    rf_load_addr = r_addr + w_idx_lo;
                end
                if (r_idx != '0) begin
                    rf_store      = 1'b1;
                    rf_store_addr = r_dst + w_idx_lo - ADDR_ONE;
                    rf_data_in    = rf_data_out;
                end
                if (r_idx == r_len) begin
                    w_state_next = S_RESP;
                end
            end
            S_FILL: begin
                rf_store      = 1'b1;
                rf_store_addr = r_addr + w_idx_lo;
                rf_data_in    = r_data;
                if (r_idx == r_len - IDX_ONE) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = r_rsp_data;
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 16x8 register unit
// (registered read, read-before-write) attached to its load/store port.
module tb_regfile_sequencer;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR       = 3'd3;
    localparam logic [2:0] ST_COPY     = 3'd4;
    localparam logic [2:0] ST_FILL     = 3'd5;
    localparam logic [2:0] ST_RESP     = 3'd6;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    localparam logic [28:0] IDLE_OUTS = {1'b1, 28'd0};

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_dst;
    logic [3:0] cmd_count;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       busy;
    logic       rf_load;
    logic       rf_store;
    logic [3:0] rf_load_addr;
    logic [3:0] rf_store_addr;
    logic [7:0] rf_data_in;
    logic [7:0] rf_data_out;
    logic [2:0] dbg_state;

    logic       mem_clr;
    logic [7:0] mem [16];

    int n_checks;
    int n_fail;

    regfile_sequencer #(
        .REGISTER_COUNT(16),
        .REGISTER_SIZE (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_dst      (cmd_dst),
        .cmd_count    (cmd_count),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .rf_load      (rf_load),
        .rf_store     (rf_store),
        .rf_load_addr (rf_load_addr),
        .rf_store_addr(rf_store_addr),
        .rf_data_in   (rf_data_in),
        .rf_data_out  (rf_data_out),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register unit model: nonblocking update gives read-before-write on same-cycle access
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int k = 0; k < 16; k++) mem[k] <= 8'h00;
            rf_data_out <= 8'h00;
        end else begin
            if (rf_load)  rf_data_out <= mem[rf_load_addr];
            if (rf_store) mem[rf_store_addr] <= rf_data_in;
        end
    end

    function automatic logic [28:0] outs();
        return {cmd_ready, rsp_valid, rsp_data, busy, rf_load, rf_store,
                rf_load_addr, rf_store_addr, rf_data_in};
    endfunction

    // Driver tasks: entered and left on a falling edge
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d,
                        input logic [3:0] c, input logic [7:0] data);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if (k >= 50) begin
            $display("FAIL send_ready_timeout cmd_ready=%b required=1", cmd_ready);
            n_fail++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_dst   = d;
        cmd_count = c;
        cmd_data  = data;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [7:0] data);
        int k;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if (k >= 50) begin
            $display("FAIL rsp_timeout rsp_valid=%b required=1", rsp_valid);
            n_fail++;
        end
        data = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] data);
        logic [7:0] dummy;
        send(OP_WRITE, a, 4'd0, 4'd0, data);
        wait_rsp(dummy);
    endtask

    task automatic do_read(input logic [3:0] a, output logic [7:0] data);
        send(OP_READ, a, 4'd0, 4'd0, 8'h00);
        wait_rsp(data);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        mem_clr = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (outs() !== IDLE_OUTS || dbg_state !== ST_IDLE) begin
            $display("FAIL reset_state outs=%h state=%0d required outs=%h state=%0d",
                     outs(), dbg_state, IDLE_OUTS, ST_IDLE);
            n_fail++;
        end
        reset   = 1'b0;
        mem_clr = 1'b0;
        @(negedge clock);
        send(OP_COPY, 4'd0, 4'd8, 4'd4, 8'h00);
        @(negedge clock);
        n_checks++;
        if (dbg_state !== ST_COPY) begin
            $display("FAIL copy_before_reset state=%0d required=%0d", dbg_state, ST_COPY);
            n_fail++;
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            n_checks++;
            if (outs() !== IDLE_OUTS || dbg_state !== ST_IDLE) begin
                $display("FAIL reset_mid_copy cyc=%0d outs=%h state=%0d required outs=%h state=%0d",
                         c, outs(), dbg_state, IDLE_OUTS, ST_IDLE);
                n_fail++;
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if (outs() !== IDLE_OUTS || dbg_state !== ST_IDLE) begin
                $display("FAIL post_reset_quiet cyc=%0d outs=%h state=%0d required outs=%h state=%0d",
                         c, outs(), dbg_state, IDLE_OUTS, ST_IDLE);
                n_fail++;
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] got;
        logic [31:0] exp;
        send(OP_WRITE, 4'd5, 4'd0, 4'd0, 8'hA7);
        got = {dbg_state, rf_load, rf_store, rf_store_addr, rf_data_in, cmd_ready, busy};
        exp = {ST_WR, 1'b0, 1'b1, 4'd5, 8'hA7, 1'b0, 1'b1};
        n_checks++;
        if (got !== exp) begin
            $display("FAIL write_store got=%h required=%h", got, exp);
            n_fail++;
        end
        @(negedge clock);
        got = {dbg_state, rsp_valid, rsp_data, rf_store, rf_load};
        exp = {ST_RESP, 1'b1, 8'h00, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin
            $display("FAIL write_resp got=%h required=%h", got, exp);
            n_fail++;
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        n_checks++;
        if (outs() !== IDLE_OUTS || dbg_state !== ST_IDLE) begin
            $display("FAIL write_one_resp_cycle outs=%h state=%0d required outs=%h state=%0d",
                     outs(), dbg_state, IDLE_OUTS, ST_IDLE);
            n_fail++;
        end
        send(OP_READ, 4'd5, 4'd0, 4'd0, 8'h00);
        got = {dbg_state, rf_load, rf_load_addr, rf_store, rsp_valid};
        exp = {ST_RD_ISSUE, 1'b1, 4'd5, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin
            $display("FAIL read_issue got=%h required=%h", got, exp);
            n_fail++;
        end
        @(negedge clock);
        got = {dbg_state, rf_load, rf_store, rsp_valid};
        exp = {ST_RD_WAIT, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin
            $display("FAIL read_wait got=%h required=%h", got, exp);
            n_fail++;
        end
        @(negedge clock);
        got = {dbg_state, rsp_valid, rsp_data};
        exp = {ST_RESP, 1'b1, 8'hA7};
        n_checks++;
        if (got !== exp) begin
            $display("FAIL read_resp got=%h required=%h", got, exp);
            n_fail++;
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_fill_wrap();
        logic [3:0]  exp_a [4];
        logic [31:0] got;
        logic [31:0] exp;
        logic [7:0]  d;
        exp_a[0] = 4'd14;
        exp_a[1] = 4'd15;
        exp_a[2] = 4'd0;
        exp_a[3] = 4'd1;
        send(OP_FILL, 4'd14, 4'd0, 4'd4, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            got = {dbg_state, rf_load, rf_store, rf_store_addr, rf_data_in};
            exp = {ST_FILL, 1'b0, 1'b1, exp_a[i], 8'h3C};
            n_checks++;
            if (got !== exp) begin
                $display("FAIL fill_store i=%0d got=%h required=%h", i, got, exp);
                n_fail++;
            end
            @(negedge clock);
        end
        got = {dbg_state, rsp_valid, rsp_data, rf_store};
        exp = {ST_RESP, 1'b1, 8'h00, 1'b0};
        n_checks++;
        if (got !== exp) begin
            $display("FAIL fill_resp got=%h required=%h", got, exp);
            n_fail++;
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        do_read(4'd0, d);
        n_checks++;
        if (d !== 8'h3C) begin
            $display("FAIL fill_read0 got=%h required=3c", d);
            n_fail++;
        end
        do_read(4'd15, d);
        n_checks++;
        if (d !== 8'h3C) begin
            $display("FAIL fill_read15 got=%h required=3c", d);
            n_fail++;
        end
    endtask

    task automatic test_copy();
        logic        el;
        logic        es;
        logic [31:0] got;
        logic [31:0] exp;
        logic [7:0]  d;
        for (int i = 0; i < 4; i++) do_write(4'(i), 8'h10 + 8'(i));
        send(OP_COPY, 4'd0, 4'd8, 4'd4, 8'h00);
        for (int i = 0; i <= 4; i++) begin
            el  = (i < 4);
            es  = (i >= 1);
            got = {dbg_state, rf_load, rf_store, el ? rf_load_addr : 4'd0,
                   es ? rf_store_addr : 4'd0, es ? rf_data_in : 8'h00};
            exp = {ST_COPY, el, es, el ? 4'(i) : 4'd0,
                   es ? 4'(8 + i - 1) : 4'd0, es ? 8'(16 + i - 1) : 8'h00};
            n_checks++;
            if (got !== exp) begin
                $display("FAIL copy_cycle i=%0d got=%h required=%h", i, got, exp);
                n_fail++;
            end
            @(negedge clock);
        end
        got = {dbg_state, rsp_valid, rsp_data, rf_load, rf_store};
        exp = {ST_RESP, 1'b1, 8'h00, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin
            $display("FAIL copy_resp got=%h required=%h", got, exp);
            n_fail++;
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_read(4'(8 + k), d);
            n_checks++;
            if (d !== 8'(16 + k)) begin
                $display("FAIL copy_readback addr=%0d got=%h required=%h", 8 + k, d, 8'(16 + k));
                n_fail++;
            end
        end
    endtask

    task automatic test_copy16_wrap();
        logic [7:0]  exp_mem [16];
        logic        el;
        logic        es;
        logic        load_wrap;
        logic        store_wrap;
        logic [3:0]  prev_la;
        logic [3:0]  prev_sa;
        logic [31:0] got;
        logic [31:0] exp;
        for (int k = 0; k < 16; k++) exp_mem[k] = 8'h00;
        exp_mem[0]  = 8'h10;  exp_mem[1]  = 8'h11;  exp_mem[2]  = 8'h12;  exp_mem[3]  = 8'h13;
        exp_mem[5]  = 8'hA7;
        exp_mem[8]  = 8'h10;  exp_mem[9]  = 8'h11;  exp_mem[10] = 8'h12;  exp_mem[11] = 8'h13;
        exp_mem[14] = 8'h3C;  exp_mem[15] = 8'h3C;
        load_wrap  = 1'b0;
        store_wrap = 1'b0;
        prev_la    = 4'd0;
        prev_sa    = 4'd0;
        send(OP_COPY, 4'd4, 4'd4, 4'd0, 8'h00);
        for (int i = 0; i <= 16; i++) begin
            el  = (i < 16);
            es  = (i >= 1);
            got = {dbg_state, rf_load, rf_store, el ? rf_load_addr : 4'd0,
                   es ? rf_store_addr : 4'd0, es ? rf_data_in : 8'h00};
            exp = {ST_COPY, el, es, el ? 4'(4 + i) : 4'd0,
                   es ? 4'(3 + i) : 4'd0, es ? exp_mem[4'(3 + i)] : 8'h00};
            n_checks++;
            if (got !== exp) begin
                $display("FAIL copy16_cycle i=%0d got=%h required=%h", i, got, exp);
                n_fail++;
            end
            if (rf_load && i > 0 && prev_la == 4'd15 && rf_load_addr == 4'd0) load_wrap = 1'b1;
            if (rf_store && i > 1 && prev_sa == 4'd15 && rf_store_addr == 4'd0) store_wrap = 1'b1;
            prev_la = rf_load_addr;
            prev_sa = rf_store_addr;
            @(negedge clock);
        end
        n_checks++;
        if (dbg_state !== ST_RESP || load_wrap !== 1'b1 || store_wrap !== 1'b1) begin
            $display("FAIL copy16_end state=%0d load_wrap=%b store_wrap=%b required state=%0d wraps=1,1",
                     dbg_state, load_wrap, store_wrap, ST_RESP);
            n_fail++;
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (mem[k] !== exp_mem[k]) begin
                $display("FAIL copy16_contents addr=%0d got=%h required=%h", k, mem[k], exp_mem[k]);
                n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        logic [31:0] exp;
        send(OP_READ, 4'd9, 4'd0, 4'd0, 8'h00);
        repeat (2) @(negedge clock);
        // A pending WRITE is presented while the response is stalled
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = 4'd6;
        cmd_dst   = 4'd0;
        cmd_count = 4'd0;
        cmd_data  = 8'h5A;
        for (int c = 0; c < 5; c++) begin
            got = {dbg_state, rsp_valid, rsp_data, cmd_ready, rf_store, rf_load};
            exp = {ST_RESP, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
            n_checks++;
            if (got !== exp) begin
                $display("FAIL stall_hold cyc=%0d got=%h required=%h", c, got, exp);
                n_fail++;
            end
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        got = {dbg_state, cmd_ready, rsp_valid};
        exp = {ST_IDLE, 1'b1, 1'b0};
        n_checks++;
        if (got !== exp) begin
            $display("FAIL stall_release got=%h required=%h", got, exp);
            n_fail++;
        end
        @(negedge clock);
        cmd_valid = 1'b0;
        got = {dbg_state, rf_store, rf_store_addr, rf_data_in};
        exp = {ST_WR, 1'b1, 4'd6, 8'h5A};
        n_checks++;
        if (got !== exp) begin
            $display("FAIL next_accept got=%h required=%h", got, exp);
            n_fail++;
        end
        @(negedge clock);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        n_checks++;
        if (mem[6] !== 8'h5A || dbg_state !== ST_IDLE) begin
            $display("FAIL next_write_done mem6=%h state=%0d required mem6=5a state=%0d",
                     mem[6], dbg_state, ST_IDLE);
            n_fail++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        mem_clr   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 4'd0;
        cmd_dst   = 4'd0;
        cmd_count = 4'd0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_fill_wrap();
        test_copy();
        test_copy16_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
